// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 decoder.
package decoder_pkg;

   localparam int CODE_W = 3;
   localparam int OUT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      SWEEP = 2'd2
   } state_e;

   function automatic logic [OUT_W-1:0] onehot3(input logic [CODE_W-1:0] code);
      logic [OUT_W-1:0] r;
      r = '0;
      r[code] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/decoder_3to8.sv
// Purely combinational 3-bit index to 8-bit one-hot line decoder.
module decoder_3to8
   import decoder_pkg::*;
(
   input  logic [CODE_W-1:0] sel,
   output logic [OUT_W-1:0]  y
);

   assign y = onehot3(sel);

endmodule

// File: rtl/decoder_3to8_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready intake, programmable
// hold time and an automatic 0..7 sweep for encoder loopback.
//
// state | meaning
// IDLE  | outputs zero, ready for a code or a sweep request
// HOLD  | single accepted code shown on y, counting down the hold time
// SWEEP | stepping idx through 0..7, each held for HOLD_CYCLES cycles
module decoder_3to8_seq
   import decoder_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CODE_W-1:0] code,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic              sweep,
   output logic [OUT_W-1:0]  y,
   output logic              v,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CODE_W-1:0] IDX_LAST = CODE_W'(OUT_W - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] idx_q, idx_d;
   logic [OUT_W-1:0]  y_q, y_d;
   logic              v_q, v_d;
   logic              done_q, done_d;

   logic [CODE_W-1:0] dec_sel;
   logic [OUT_W-1:0]  dec_y;
   logic              load_y;
   logic              clear_y;

   // The decoder sees the index that y is about to show, so y stays a
   // plain register of a single decoder output.
   decoder_3to8 u_dec (
      .sel (dec_sel),
      .y   (dec_y)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      y_d     = y_q;
      v_d     = v_q;
      done_d  = 1'b0;
      dec_sel = idx_q;
      load_y  = 1'b0;
      clear_y = 1'b0;

      if (en) begin
         unique case (state_q)
            IDLE: begin
               if (sweep) begin
                  state_d = SWEEP;
                  idx_d   = '0;
                  dec_sel = '0;
                  load_y  = 1'b1;
                  cnt_d   = CNT_LOAD;
               end else if (valid_in) begin
                  state_d = HOLD;
                  dec_sel = code;
                  load_y  = 1'b1;
                  cnt_d   = CNT_LOAD;
               end
            end
            HOLD: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = IDLE;
                  clear_y = 1'b1;
               end
            end
            SWEEP: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (idx_q != IDX_LAST) begin
                  idx_d   = idx_q + CODE_W'(1);
                  dec_sel = idx_q + CODE_W'(1);
                  load_y  = 1'b1;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = IDLE;
                  clear_y = 1'b1;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               clear_y = 1'b1;
               cnt_d   = '0;
            end
         endcase
      end

      if (load_y) begin
         y_d = dec_y;
         v_d = 1'b1;
      end else if (clear_y) begin
         y_d = '0;
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         y_q     <= '0;
         v_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
         v_q     <= v_d;
         done_q  <= done_d;
      end
   end

   assign y         = y_q;
   assign v         = v_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign ready_out = (state_q == IDLE) && !sweep;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed self-checking bench: one instance with a 4-cycle hold, one with 2.
module tb_decoder_3to8_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] code;
   logic       valid_in;
   logic       sweep;

   logic       ready_a, v_a, busy_a, done_a;
   logic [7:0] y_a;
   logic       ready_b, v_b, busy_b, done_b;
   logic [7:0] y_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decoder_3to8_seq #(.HOLD_CYCLES(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .code      (code),
      .valid_in  (valid_in),
      .ready_out (ready_a),
      .sweep     (sweep),
      .y         (y_a),
      .v         (v_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   decoder_3to8_seq #(.HOLD_CYCLES(2)) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .code      (code),
      .valid_in  (valid_in),
      .ready_out (ready_b),
      .sweep     (sweep),
      .y         (y_b),
      .v         (v_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc8(input logic [7:0] yy);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++)
         if (yy[i]) r = i;
      return r;
   endfunction

   task automatic chk_idle_a(input string tag);
      chk({tag, "_y"}, y_a, 8'h00);
      chk({tag, "_v"}, v_a, 1'b0);
      chk({tag, "_done"}, done_a, 1'b0);
      chk({tag, "_ready"}, ready_a, 1'b1);
      chk({tag, "_busy"}, busy_a, 1'b0);
   endtask

   initial begin
      int waited;

      rst = 1'b1; en = 1'b1; code = 3'd0; valid_in = 1'b0; sweep = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk_idle_a("reset");
      chk("reset_y2", y_b, 8'h00);
      chk("reset_ready2", ready_b, 1'b1);

      // single decode of code 3, with a stray valid during the hold
      code = 3'd3; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      chk("single_y_t0", y_a, 8'h08);
      chk("single_v_t0", v_a, 1'b1);
      chk("single_ready_t0", ready_a, 1'b0);
      chk("single_busy_t0", busy_a, 1'b1);
      code = 3'd7; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      chk("single_y_t1", y_a, 8'h08);
      step();
      chk("single_y_t2", y_a, 8'h08);
      step();
      chk("single_y_t3", y_a, 8'h08);
      step();
      chk_idle_a("single_t4");

      // every code back to back, with encoder loopback of the output
      for (int k = 0; k < 8; k++) begin
         waited = 0;
         while (!ready_a && waited < 20) begin
            step();
            waited++;
         end
         chk("exh_ready_bound", (waited < 20), 1'b1);
         code = 3'(k); valid_in = 1'b1;
         step();
         valid_in = 1'b0;
         chk("exh_y", y_a, 32'(8'h01 << k));
         chk("exh_enc", enc8(y_a), k);
         chk("exh_v", v_a, 1'b1);
         for (int j = 0; j < 4; j++) begin
            step();
            chk("exh_onehot0", $onehot0(y_a), 1'b1);
            chk("exh_v_eq_or", v_a, |y_a);
         end
         chk("exh_drop", y_a, 8'h00);
      end

      // reset in the middle of a hold of code 5
      code = 3'd5; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      chk("rst_pre_y", y_a, 8'h20);
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk_idle_a("rst_mid_hold");

      // sweep on both instances; request drops mid-sweep
      sweep = 1'b1;
      step();
      sweep = 1'b0;
      for (int j = 0; j < 16; j++) begin
         chk("sweep2_y", y_b, 32'(8'h01 << (j / 2)));
         chk("sweep2_done", done_b, 1'b0);
         chk("sweep2_ready", ready_b, 1'b0);
         chk("sweep4_y", y_a, 32'(8'h01 << (j / 4)));
         step();
      end
      chk("sweep2_end_y", y_b, 8'h00);
      chk("sweep2_end_done", done_b, 1'b1);
      chk("sweep2_end_v", v_b, 1'b0);
      chk("sweep4_mid_y", y_a, 8'h10);
      step();
      chk("sweep2_done_pulse", done_b, 1'b0);
      for (int j = 17; j < 32; j++) begin
         chk("sweep4_y_late", y_a, 32'(8'h01 << (j / 4)));
         chk("sweep4_done_early", done_a, 1'b0);
         step();
      end
      chk("sweep4_end_y", y_a, 8'h00);
      chk("sweep4_end_done", done_a, 1'b1);
      step();
      chk("sweep4_done_pulse", done_a, 1'b0);

      // sweep and valid together: sweep wins, code 6 dropped
      sweep = 1'b1; valid_in = 1'b1; code = 3'd6;
      #1;
      chk("both_ready", ready_a, 1'b0);
      step();
      sweep = 1'b0; valid_in = 1'b0;
      chk("both_y", y_a, 8'h01);
      chk("both_busy", busy_a, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle_a("both_reset");

      // en low for three cycles during a hold of code 2
      code = 3'd2; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      chk("en_y_t0", y_a, 8'h04);
      step();
      chk("en_y_t1", y_a, 8'h04);
      en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("en_frozen_y", y_a, 8'h04);
         chk("en_frozen_busy", busy_a, 1'b1);
      end
      en = 1'b1;
      step();
      chk("en_resume_y1", y_a, 8'h04);
      step();
      chk("en_resume_y2", y_a, 8'h04);
      step();
      chk_idle_a("en_resume_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
